vram_port_arbiter: RTL
======================

# vram_port_arbiter

Shares the second exmem port (video port) between three requesters: the BitGen pixel fetch (video read), a game-logic trail writer, and an optional built-in screen-clear engine. It sits between BitGen/game logic and the exmem dataIn2/addr2/we2/dataOut2 pins. Video reads have priority, bounded by a starvation guard so trail writes always complete.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width
- STARVE_LIMIT, 8, max cycles a pending write waits before it pre-empts video (1..255)

- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-low; one clock, reset async active-low
- vid_req  in  1  video read request (held by BitGen while it needs a word)
- vid_addr  in  ADDR_W  video read address
- vid_stall  out  1  video request denied this cycle (combinational)
- vid_valid  out  1  vid_rdata valid (registered)
- vid_rdata  out  DATA_W  read data (registered)
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  write granted this cycle (combinational)
- clear_start  in  1  one-cycle pulse: start fill
- clear_base  in  ADDR_W  first fill address
- clear_len  in  ADDR_W  number of words to fill
- clear_value  in  DATA_W  fill word
- clear_busy  out  1  fill in progress
- clear_done  out  1  one-cycle pulse at fill completion
- mem_addr  out  ADDR_W  to exmem addr2
- mem_din  out  DATA_W  to exmem dataIn2
- mem_we  out  1  to exmem we2
- mem_dout  in  DATA_W  from exmem dataOut2

## Operation
- One grant per cycle, decided combinationally from current requests:
  1. writer, if wr_req and wait_cnt == STARVE_LIMIT (pre-emption);
  2. video, if vid_req;
  3. writer, if wr_req;
  4. clear engine, if clear_busy;
  5. none: mem_we=0, mem_addr=vid_addr, mem_din=0.
- vid_stall = vid_req & ~video_granted.
- wait_cnt (8 bit): +1 each cycle wr_req & ~wr_ack, saturating at STARVE_LIMIT; cleared on wr_ack or wr_req low.
- Clear engine FSM: IDLE -> FILL on clear_start (latch base, len, value; cnt=0). FILL: each granted cycle write clear_value to base+cnt, cnt+1; when cnt reaches len -> DONE. DONE: clear_done=1 for one cycle -> IDLE.
- clear_len == 0: IDLE -> DONE directly, no writes.
- clear_start while busy: ignored.
- Fill addresses wrap modulo 2^ADDR_W.
- Writer and video access are unaffected by an active fill except losing no priority.

## Timing
- Reset values: vid_valid=0, vid_rdata=0, clear_busy=0, clear_done=0, wait_cnt=0, FSM=IDLE; combinational outputs follow their equations (all requests low -> mem_we=0, wr_ack=0, vid_stall=0).
- Video read latency 1: grant in cycle N, exmem captures on negedge N, vid_rdata registered from mem_dout at posedge N+1, vid_valid=1 during N+1. Back-to-back grants give one word per cycle.
- Write commits in grant cycle (exmem negedge); wr_ack high that cycle; requester may drop or change wr_req next cycle.
- Pre-emption cycle: vid_stall=1, vid_valid=0 in the following cycle.
- Worst-case write latency from wr_req to wr_ack: STARVE_LIMIT+1 cycles.
- reset asserted mid-fill: fill aborted, no clear_done pulse.

## Configuration
- VRAM_ARB_CLEAR_EN defined: clear engine and FSM present as described.
- Not defined: clear engine removed; clear_busy=0, clear_done=0, clear_start/base/len/value ignored; priority levels 4 and 5 collapse to "none".

## Test plan
- Reset then vid_req with vid_addr=0x0010, memory word 0xBEEF -> vid_valid=1 next cycle, vid_rdata=0xBEEF, vid_stall=0.
- wr_req alone, wr_addr=0x0020, wr_data=0x1234 -> wr_ack and mem_we same cycle; later read of 0x0020 returns 0x1234.
- vid_req held continuously, wr_req raised at cycle 0, STARVE_LIMIT=8 -> wr_ack at cycle 8, vid_stall=1 that cycle, vid_valid=0 cycle 9, wait_cnt=0 cycle 9.
- clear_start with base=0xFFFE, len=4, value=0x0000, no other requests -> writes 0xFFFE,0xFFFF,0x0000,0x0001 in 4 consecutive cycles, clear_done one cycle later, clear_busy low after.
- clear with len=0 -> clear_done next cycle, mem_we never asserted; clear with video active -> fill writes only in vid_req-low cycles.
- reset pulsed mid-fill after 2 of 10 writes -> clear_busy=0 immediately, no clear_done, no further writes.

Source files
------------

// File: rtl/vram_port_arbiter_if.sv
// Bundle of the video, trail-writer, clear-engine and exmem port-2 signals of vram_port_arbiter.
// master = requesters + memory side, slave = the arbiter.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_stall;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_rdata;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              clear_start;
    logic [ADDR_W-1:0] clear_base;
    logic [ADDR_W-1:0] clear_len;
    logic [DATA_W-1:0] clear_value;
    logic              clear_busy;
    logic              clear_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output vid_req, vid_addr, wr_req, wr_addr, wr_data,
               clear_start, clear_base, clear_len, clear_value, mem_dout,
        input  vid_stall, vid_valid, vid_rdata, wr_ack, clear_busy, clear_done,
               mem_addr, mem_din, mem_we
    );

    modport slave (
        input  vid_req, vid_addr, wr_req, wr_addr, wr_data,
               clear_start, clear_base, clear_len, clear_value, mem_dout,
        output vid_stall, vid_valid, vid_rdata, wr_ack, clear_busy, clear_done,
               mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Arbitrates exmem port 2 between video reads, trail writes and a screen-clear engine.
// Define VRAM_ARB_CLEAR_EN to build the clear engine; otherwise it is absent.
module vram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input logic clk,
    input logic reset,
    vram_port_arbiter_if.slave bus
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              vid_valid_q;
    logic [DATA_W-1:0] vid_rdata_q;
    logic              preempt, vid_gnt, wr_gnt, clr_gnt;
    logic              clr_busy, clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_value;

    // A writer that has waited STARVE_LIMIT cycles outranks video.
    assign preempt = bus.wr_req && (wait_cnt_q == LIMIT);
    assign vid_gnt = bus.vid_req && !preempt;
    assign wr_gnt  = bus.wr_req && !vid_gnt;
    assign clr_gnt = clr_busy && !bus.vid_req && !bus.wr_req;

    assign bus.vid_stall  = bus.vid_req && !vid_gnt;
    assign bus.wr_ack     = wr_gnt;
    assign bus.vid_valid  = vid_valid_q;
    assign bus.vid_rdata  = vid_rdata_q;
    assign bus.clear_busy = clr_busy;
    assign bus.clear_done = clr_done;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bus.mem_addr = bus.vid_addr;
        bus.mem_din  = '0;
        bus.mem_we   = 1'b0;
        if (wr_gnt) begin
            bus.mem_addr = bus.wr_addr;
            bus.mem_din  = bus.wr_data;
            bus.mem_we   = 1'b1;
        end else if (clr_gnt) begin
            bus.mem_addr = clr_addr;
            bus.mem_din  = clr_value;
            bus.mem_we   = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (bus.wr_req && !wr_gnt)
            wait_cnt_d = (wait_cnt_q == LIMIT) ? LIMIT : wait_cnt_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_rdata_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            vid_valid_q <= vid_gnt;
            if (vid_gnt)
                vid_rdata_q <= bus.mem_dout;
        end
    end

`ifdef VRAM_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, FILL, DONE} clr_state_e;

    clr_state_e        clr_state_q;
    logic [ADDR_W-1:0] clr_base_q, clr_len_q, clr_cnt_q, clr_cnt_inc;
    logic [DATA_W-1:0] clr_value_q;
    logic              clr_busy_q, clr_done_q;

    assign clr_cnt_inc = clr_cnt_q + ADDR_W'(1);
    assign clr_addr    = clr_base_q + clr_cnt_q;
    assign clr_value   = clr_value_q;
    assign clr_busy    = clr_busy_q;
    assign clr_done    = clr_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_state_q <= IDLE;
            clr_base_q  <= '0;
            clr_len_q   <= '0;
            clr_cnt_q   <= '0;
            clr_value_q <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            case (clr_state_q)
                IDLE: if (bus.clear_start) begin
                    clr_base_q  <= bus.clear_base;
                    clr_len_q   <= bus.clear_len;
                    clr_value_q <= bus.clear_value;
                    clr_cnt_q   <= '0;
                    if (bus.clear_len == '0) begin
                        clr_state_q <= DONE;
                        clr_done_q  <= 1'b1;
                    end else begin
                        clr_state_q <= FILL;
                        clr_busy_q  <= 1'b1;
                    end
                end
                FILL: if (clr_gnt) begin
                    clr_cnt_q <= clr_cnt_inc;
                    if (clr_cnt_inc == clr_len_q) begin
                        clr_state_q <= DONE;
                        clr_busy_q  <= 1'b0;
                        clr_done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    clr_done_q  <= 1'b0;
                    clr_state_q <= IDLE;
                end
                default: begin
                    clr_state_q <= IDLE;
                    clr_busy_q  <= 1'b0;
                    clr_done_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_clear;

    assign unused_clear = ^{bus.clear_start, bus.clear_base, bus.clear_len, bus.clear_value};
    assign clr_busy     = 1'b0;
    assign clr_done     = 1'b0;
    assign clr_addr     = '0;
    assign clr_value    = '0;
`endif
endmodule
